// File: rtl/uart_receiver.sv
// UART receiver: oversampled serial line to parallel word, with per-frame parity and framing
// error pulses. Each bit is a 3-sample majority vote taken around mid-bit.
module uart_receiver #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  parity_type,
  input  logic                  parity_enable,
  input  logic                  serial_data_in,
  output logic [DATA_WIDTH-1:0] parallel_data,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(PRESCALE);
  localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(PRESCALE - 1);
  localparam logic [CntW-1:0] CntS0   = CntW'(PRESCALE / 2 - 1);
  localparam logic [CntW-1:0] CntS1   = CntW'(PRESCALE / 2);
  localparam logic [CntW-1:0] CntDec  = CntW'(PRESCALE / 2 + 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_t;

  state_t                r_state, w_state_next;
  logic                  r_sync1, r_rx_s, r_rx_prev;
  logic [CntW-1:0]       r_cnt, w_cnt_next;
  logic [BitW-1:0]       r_bit_cnt, w_bit_cnt_next;
  logic                  r_samp0, w_samp0_next, r_samp1, w_samp1_next;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
  logic [DATA_WIDTH-1:0] r_data, w_data_next;
  logic                  r_par_bad, w_par_bad_next;
  logic                  r_par_type, w_par_type_next, r_par_en, w_par_en_next;
  logic                  r_valid, w_valid_next, r_perr, w_perr_next, r_ferr, w_ferr_next;
  logic                  w_decision, w_at_dec, w_wrap, w_par_exp;

  assign w_decision = (r_samp0 & r_samp1) | (r_samp0 & r_rx_s) | (r_samp1 & r_rx_s);
  assign w_at_dec   = (r_cnt == CntDec);
  assign w_wrap     = (r_cnt == CntLast);
  assign w_par_exp  = r_par_type ? ~^r_shift : ^r_shift;

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_bit_cnt_next  = r_bit_cnt;
    w_samp0_next    = (r_cnt == CntS0) ? r_rx_s : r_samp0;
    w_samp1_next    = (r_cnt == CntS1) ? r_rx_s : r_samp1;
    w_shift_next    = r_shift;
    w_data_next     = r_data;
    w_par_bad_next  = r_par_bad;
    w_par_type_next = r_par_type;
    w_par_en_next   = r_par_en;
    w_valid_next    = 1'b0;
    w_perr_next     = 1'b0;
    w_ferr_next     = 1'b0;

    if (r_state != StIdle) begin
      w_cnt_next = w_wrap ? '0 : r_cnt + 1'b1;
    end

    case (r_state)
      StIdle: begin
        w_cnt_next = '0;
        // The T0 cycle itself is sample 0 of the start bit.
        if (!r_rx_s && r_rx_prev) begin
          w_state_next    = StStart;
          w_cnt_next      = CntW'(1);
          w_bit_cnt_next  = '0;
          w_par_bad_next  = 1'b0;
          w_par_type_next = parity_type;
          w_par_en_next   = parity_enable;
        end
      end
      StStart: begin
        if (w_at_dec && w_decision) begin
          w_state_next = StIdle;
          w_cnt_next   = '0;
        end else if (w_wrap) begin
          w_state_next = StData;
        end
      end
      StData: begin
        if (w_at_dec) begin
          w_shift_next = {w_decision, r_shift[DATA_WIDTH-1:1]};
        end
        if (w_wrap) begin
          if (r_bit_cnt == BitLast) begin
            w_bit_cnt_next = '0;
            w_state_next   = r_par_en ? StParity : StStop;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end
      end
      StParity: begin
        if (w_at_dec && (w_decision != w_par_exp)) begin
          w_par_bad_next = 1'b1;
        end
        if (w_wrap) begin
          w_state_next = StStop;
        end
      end
      StStop: begin
        // Leave at mid stop bit so a zero-gap following start edge is not missed.
        if (w_at_dec) begin
          w_state_next = StIdle;
          w_cnt_next   = '0;
          w_ferr_next  = ~w_decision;
          w_perr_next  = r_par_bad;
          if (w_decision && !r_par_bad) begin
            w_valid_next = 1'b1;
            w_data_next  = r_shift;
          end
        end
      end
      default: begin
        w_state_next = StIdle;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_sync1    <= 1'b1;
      r_rx_s     <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
      r_samp0    <= 1'b1;
      r_samp1    <= 1'b1;
      r_shift    <= '0;
      r_data     <= '0;
      r_par_bad  <= 1'b0;
      r_par_type <= 1'b0;
      r_par_en   <= 1'b0;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_sync1    <= serial_data_in;
      r_rx_s     <= r_sync1;
      r_rx_prev  <= r_rx_s;
      r_cnt      <= w_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_samp0    <= w_samp0_next;
      r_samp1    <= w_samp1_next;
      r_shift    <= w_shift_next;
      r_data     <= w_data_next;
      r_par_bad  <= w_par_bad_next;
      r_par_type <= w_par_type_next;
      r_par_en   <= w_par_en_next;
      r_valid    <= w_valid_next;
      r_perr     <= w_perr_next;
      r_ferr     <= w_ferr_next;
    end
  end

  assign parallel_data = r_data;
  assign data_valid    = r_valid;
  assign parity_error  = r_perr;
  assign framing_error = r_ferr;
  assign busy          = (r_state != StIdle);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: expected pulses are queued as frames are driven and
// popped by a monitor when the DUT emits a valid/error pulse.
module tb_uart_receiver;
  localparam int DW  = 8;
  localparam int PRE = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          parity_type = 1'b0;
  logic          parity_enable = 1'b0;
  logic          serial_data_in = 1'b1;
  logic [DW-1:0] parallel_data;
  logic          data_valid, parity_error, framing_error, busy;

  typedef struct packed {
    logic          v;
    logic          pe;
    logic          fe;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_pulse_cyc = 0;
  int   prev_pulse_cyc = 0;
  logic busy_prev = 1'b0;
  logic pulse_busy = 1'b0;
  logic pulse_busy_prev = 1'b0;

  uart_receiver #(.DATA_WIDTH(DW), .PRESCALE(PRE)) dut (
    .clk            (clk),
    .reset          (reset),
    .parity_type    (parity_type),
    .parity_enable  (parity_enable),
    .serial_data_in (serial_data_in),
    .parallel_data  (parallel_data),
    .data_valid     (data_valid),
    .parity_error   (parity_error),
    .framing_error  (framing_error),
    .busy           (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    if (data_valid || parity_error || framing_error) begin
      prev_pulse_cyc  = last_pulse_cyc;
      last_pulse_cyc  = cyc;
      pulse_busy      = busy;
      pulse_busy_prev = busy_prev;
      got = {data_valid, parity_error, framing_error, parallel_data};
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_pulse: got v=%b pe=%b fe=%b data=%h, required no pulse",
                 data_valid, parity_error, framing_error, parallel_data);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          n_errors++;
          $display("FAIL sb_pulse: got v=%b pe=%b fe=%b data=%h, required v=%b pe=%b fe=%b data=%h",
                   got.v, got.pe, got.fe, got.d, e.v, e.pe, e.fe, e.d);
        end
      end
    end
    busy_prev = busy;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic par(input logic [DW-1:0] d, input logic t);
    return t ? ~^d : ^d;
  endfunction

  // Caller must be aligned #1 after a posedge; returns aligned the same way.
  task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic pbit,
                            input logic stop, output int fall_cyc);
    serial_data_in = 1'b0;
    fall_cyc = cyc;
    repeat (PRE) @(posedge clk);
    #1;
    for (int i = 0; i < DW; i++) begin
      serial_data_in = d[i];
      repeat (PRE) @(posedge clk);
      #1;
    end
    if (pen) begin
      serial_data_in = pbit;
      repeat (PRE) @(posedge clk);
      #1;
    end
    serial_data_in = stop;
    repeat (PRE) @(posedge clk);
    #1;
    serial_data_in = 1'b1;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 * PRE; i++) begin
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (parallel_data !== '0) begin
      n_errors++;
      $display("FAIL reset_data: got %h, required 00", parallel_data);
    end
    n_checks++;
    if ({data_valid, parity_error, framing_error, busy} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_flags: got %b, required 0000",
               {data_valid, parity_error, framing_error, busy});
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int fall;
    bit ok;
    parity_enable = 1'b1;
    parity_type   = 1'b0;
    sb.push_back(exp_t'({1'b1, 1'b0, 1'b0, 8'hE6}));
    send_frame(8'hE6, 1'b1, par(8'hE6, 1'b0), 1'b1, fall);
    wait_drain(ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL basic_drain: got %0d pending, required 0", sb.size());
    end
    n_checks++;
    if (last_pulse_cyc - fall !== 2 + 10 * PRE + PRE / 2 + 1 + 1) begin
      n_errors++;
      $display("FAIL basic_latency: got %0d cycles, required %0d", last_pulse_cyc - fall,
               2 + 10 * PRE + PRE / 2 + 2);
    end
    n_checks++;
    if ({pulse_busy_prev, pulse_busy} !== 2'b10) begin
      n_errors++;
      $display("FAIL basic_busy_drop: got prev/at-pulse %b, required 10",
               {pulse_busy_prev, pulse_busy});
    end
  endtask

  task automatic test_config();
    int fall;
    bit ok;
    parity_type = 1'b1;
    sb.push_back(exp_t'({1'b1, 1'b0, 1'b0, 8'hFF}));
    send_frame(8'hFF, 1'b1, par(8'hFF, 1'b1), 1'b1, fall);
    parity_enable = 1'b0;
    sb.push_back(exp_t'({1'b1, 1'b0, 1'b0, 8'hF4}));
    send_frame(8'hF4, 1'b0, 1'b0, 1'b1, fall);
    wait_drain(ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL config_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_errors();
    int fall;
    bit ok;
    parity_enable = 1'b1;
    parity_type   = 1'b0;
    sb.push_back(exp_t'({1'b0, 1'b1, 1'b0, 8'hF4}));
    send_frame(8'hE6, 1'b1, ~par(8'hE6, 1'b0), 1'b1, fall);
    sb.push_back(exp_t'({1'b0, 1'b0, 1'b1, 8'hF4}));
    send_frame(8'h5A, 1'b1, par(8'h5A, 1'b0), 1'b0, fall);
    wait_drain(ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL errors_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_glitch();
    int fall;
    int busy_cnt;
    bit ok;
    busy_cnt = 0;
    serial_data_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    serial_data_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (busy_cnt < 1 || busy_cnt > PRE / 2 + 2) begin
      n_errors++;
      $display("FAIL glitch_busy: got %0d busy cycles, required 1..%0d", busy_cnt, PRE / 2 + 2);
    end
    sb.push_back(exp_t'({1'b1, 1'b0, 1'b0, 8'h3C}));
    send_frame(8'h3C, 1'b1, par(8'h3C, 1'b0), 1'b1, fall);
    wait_drain(ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL glitch_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int fall;
    bit ok;
    sb.push_back(exp_t'({1'b1, 1'b0, 1'b0, 8'h01}));
    sb.push_back(exp_t'({1'b1, 1'b0, 1'b0, 8'h80}));
    send_frame(8'h01, 1'b1, par(8'h01, 1'b0), 1'b1, fall);
    send_frame(8'h80, 1'b1, par(8'h80, 1'b0), 1'b1, fall);
    wait_drain(ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL b2b_drain: got %0d pending, required 0", sb.size());
    end
    n_checks++;
    if (last_pulse_cyc - prev_pulse_cyc !== 11 * PRE) begin
      n_errors++;
      $display("FAIL b2b_spacing: got %0d cycles, required %0d",
               last_pulse_cyc - prev_pulse_cyc, 11 * PRE);
    end
  endtask

  task automatic test_reset_midframe();
    int fall;
    bit ok;
    fork
      send_frame(8'hA5, 1'b1, par(8'hA5, 1'b0), 1'b1, fall);
      begin
        repeat (5 * PRE + PRE / 2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1) begin
          n_errors++;
          $display("FAIL midframe_busy: got %b, required 1", busy);
        end
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (parallel_data !== '0) begin
          n_errors++;
          $display("FAIL abort_data: got %h, required 00", parallel_data);
        end
        n_checks++;
        if ({data_valid, parity_error, framing_error, busy} !== 4'b0000) begin
          n_errors++;
          $display("FAIL abort_flags: got %b, required 0000",
                   {data_valid, parity_error, framing_error, busy});
        end
      end
    join
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sb.push_back(exp_t'({1'b1, 1'b0, 1'b0, 8'hA5}));
    send_frame(8'hA5, 1'b1, par(8'hA5, 1'b0), 1'b1, fall);
    wait_drain(ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL after_reset_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_config();
    test_errors();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
